// File: rtl/pinmux_pad_attr_writer.sv
// Pad attribute writer: accepts attribute updates from the pinmux register
// file, forwards each one to the addressed pad over a req/ack handshake, and
// keeps a shadow copy of the value the pad actually took (masked by PadType).
module pinmux_pad_attr_writer #(
   parameter int NPads         = 4,
   parameter int AttrDw        = 13,
   parameter int PadType       = 0,
   parameter int TimeoutCycles = 15,
   localparam int IdxW         = (NPads > 1) ? $clog2(NPads) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_req_i,
   input  logic [IdxW-1:0]   wr_idx_i,
   input  logic [AttrDw-1:0] wr_attr_i,
   output logic              wr_ready_o,
   output logic              pad_req_o,
   output logic [IdxW-1:0]   pad_idx_o,
   output logic [AttrDw-1:0] pad_attr_o,
   input  logic              pad_ack_i,
   input  logic [AttrDw-1:0] pad_attr_i,
   input  logic [IdxW-1:0]   rd_idx_i,
   output logic [AttrDw-1:0] rd_attr_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   input  logic              err_clr_i
);

   // Bits the pad flavour allows software to write; all others read as 0.
   localparam logic [AttrDw-1:0] AttrMask =
      (PadType == 0) ? {AttrDw{1'b1}} :
      (PadType == 1) ? AttrDw'(3)     :
      (PadType == 2) ? AttrDw'(15)    : '0;

   // Counter only needs to reach TimeoutCycles-1.
   localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
   localparam logic [IdxW:0]   NPadsW  = (IdxW + 1)'(NPads);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q;
   logic [IdxW-1:0]   pad_idx_q;
   logic [AttrDw-1:0] pad_attr_q;
   logic              done_q;
   logic              err_q;
   logic [AttrDw-1:0] shadow_q [NPads];

   logic idx_ok;
   logic start;
   logic bad_idx;
   logic ack_ok;
   logic timeout;

   assign idx_ok = ({1'b0, wr_idx_i} < NPadsW);

   // Next-state logic and the single-cycle events that drive the datapath.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      start   = 1'b0;
      bad_idx = 1'b0;
      ack_ok  = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_req_i) begin
               if (idx_ok) begin
                  start   = 1'b1;
                  state_d = REQ;
               end else begin
                  bad_idx = 1'b1;
               end
            end
         end
         REQ: begin
            // An ack on the last allowed cycle still counts as success.
            if (pad_ack_i) begin
               ack_ok  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CntLast) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Request payload and REQ-cycle counter, captured on accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pad_idx_q  <= '0;
         pad_attr_q <= '0;
         cnt_q      <= '0;
      end else if (start) begin
         pad_idx_q  <= wr_idx_i;
         pad_attr_q <= wr_attr_i & AttrMask;
         cnt_q      <= '0;
      end else if (state_q == REQ && !pad_ack_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Completion pulse and sticky error flag (set beats clear).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= ack_ok;
         if (timeout || bad_idx) err_q <= 1'b1;
         else if (err_clr_i)     err_q <= 1'b0;
      end
   end

   // Shadow of the value each pad reported back, masked to writable bits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: the shadow is small and must read 0 after reset, so it is built from resettable flops.
      if (rst_i) begin
         for (int i = 0; i < NPads; i++) shadow_q[i] <= '0;
      end else if (ack_ok) begin
         for (int i = 0; i < NPads; i++) begin
            if (pad_idx_q == IdxW'(i)) shadow_q[i] <= pad_attr_i & AttrMask;
         end
      end
   end

   // Combinational shadow read; indices with no pad read as 0.
   always_comb begin
      rd_attr_o = '0;
      for (int i = 0; i < NPads; i++) begin
         if (rd_idx_i == IdxW'(i)) rd_attr_o = shadow_q[i];
      end
   end

   assign wr_ready_o = (state_q == IDLE);
   assign busy_o     = (state_q == REQ);
   assign pad_req_o  = (state_q == REQ);
   assign pad_idx_o  = pad_idx_q;
   assign pad_attr_o = pad_attr_q;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_pinmux_pad_attr_writer.sv
// Bench for pinmux_pad_attr_writer. Two instances share all inputs:
//   u_a: NPads=4, PadType=0 (full mask)
//   u_b: NPads=3, PadType=1 (mask 13'h0003), so index 3 is out of range
// Expectations come from a transaction-level model: per-pad shadow arrays,
// sticky error flags, and the ack-cycle / timeout rules of the handshake.
module tb_pinmux_pad_attr_writer;

   localparam int Tmo = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req;
   logic [1:0]  wr_idx;
   logic [12:0] wr_attr;
   logic        pad_ack;
   logic [12:0] pad_attr_in;
   logic [1:0]  rd_idx;
   logic        err_clr;

   logic        ready_a, req_a, busy_a, done_a, err_a;
   logic [1:0]  pidx_a;
   logic [12:0] pattr_a, rd_a;
   logic        ready_b, req_b, busy_b, done_b, err_b;
   logic [1:0]  pidx_b;
   logic [12:0] pattr_b, rd_b;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [12:0] sh_a [4];
   logic [12:0] sh_b [4];
   logic        exp_err_a, exp_err_b;

   always #5 clk = ~clk;

   pinmux_pad_attr_writer #(.NPads(4), .AttrDw(13), .PadType(0), .TimeoutCycles(Tmo)) u_a (
      .clk_i(clk), .rst_i(rst), .wr_req_i(wr_req), .wr_idx_i(wr_idx), .wr_attr_i(wr_attr),
      .wr_ready_o(ready_a), .pad_req_o(req_a), .pad_idx_o(pidx_a), .pad_attr_o(pattr_a),
      .pad_ack_i(pad_ack), .pad_attr_i(pad_attr_in), .rd_idx_i(rd_idx), .rd_attr_o(rd_a),
      .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .err_clr_i(err_clr));

   pinmux_pad_attr_writer #(.NPads(3), .AttrDw(13), .PadType(1), .TimeoutCycles(Tmo)) u_b (
      .clk_i(clk), .rst_i(rst), .wr_req_i(wr_req), .wr_idx_i(wr_idx), .wr_attr_i(wr_attr),
      .wr_ready_o(ready_b), .pad_req_o(req_b), .pad_idx_o(pidx_b), .pad_attr_o(pattr_b),
      .pad_ack_i(pad_ack), .pad_attr_i(pad_attr_in), .rd_idx_i(rd_idx), .rd_attr_o(rd_b),
      .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .err_clr_i(err_clr));

   function automatic logic [12:0] mask_of(input int pad_type);
      case (pad_type)
         0:       return 13'h1FFF;
         1:       return 13'h0003;
         2:       return 13'h000F;
         default: return 13'h0000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Read every shadow entry of both instances and compare with the model.
   task automatic sweep_shadows(input string tag);
      for (int i = 0; i < 4; i++) begin
         rd_idx = 2'(i);
         #1;
         chk($sformatf("%s rd_a[%0d]", tag, i), 32'(rd_a), 32'(sh_a[i]));
         chk($sformatf("%s rd_b[%0d]", tag, i), 32'(rd_b), (i < 3) ? 32'(sh_b[i]) : 32'd0);
      end
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      exp_err_a = 1'b0;
      exp_err_b = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr err_a", 32'(err_a), 32'(exp_err_a));
      chk("clr err_b", 32'(err_b), 32'(exp_err_b));
   endtask

   // One update. The pad acks at REQ cycle k (k > Tmo means never);
   // err_clr_i is raised during cycle clr_cycle (0 = never).
   task automatic do_write(input string tag, input logic [1:0] idx, input logic [12:0] attr,
                           input int k, input logic [12:0] ret, input int clr_cycle);
      logic bad_b;
      logic ack, to;
      bad_b = (idx >= 2'd3);
      @(negedge clk);
      chk({tag, " c0 ready_a"}, 32'(ready_a), 32'd1);
      chk({tag, " c0 ready_b"}, 32'(ready_b), 32'd1);
      chk({tag, " c0 done_a"}, 32'(done_a), 32'd0);
      wr_req  = 1'b1;
      wr_idx  = idx;
      wr_attr = attr;
      @(posedge clk);
      if (bad_b) exp_err_b = 1'b1;
      for (int c = 1; c <= Tmo; c++) begin
         @(negedge clk);
         wr_req = 1'b0;
         chk($sformatf("%s c%0d req_a", tag, c), 32'(req_a), 32'd1);
         chk($sformatf("%s c%0d busy_a", tag, c), 32'(busy_a), 32'd1);
         chk($sformatf("%s c%0d ready_a", tag, c), 32'(ready_a), 32'd0);
         chk($sformatf("%s c%0d done_a", tag, c), 32'(done_a), 32'd0);
         chk($sformatf("%s c%0d idx_a", tag, c), 32'(pidx_a), 32'(idx));
         chk($sformatf("%s c%0d attr_a", tag, c), 32'(pattr_a), 32'(attr & mask_of(0)));
         chk($sformatf("%s c%0d err_a", tag, c), 32'(err_a), 32'(exp_err_a));
         chk($sformatf("%s c%0d err_b", tag, c), 32'(err_b), 32'(exp_err_b));
         chk($sformatf("%s c%0d done_b", tag, c), 32'(done_b), 32'd0);
         if (bad_b) begin
            chk($sformatf("%s c%0d req_b", tag, c), 32'(req_b), 32'd0);
            chk($sformatf("%s c%0d ready_b", tag, c), 32'(ready_b), 32'd1);
         end else begin
            chk($sformatf("%s c%0d req_b", tag, c), 32'(req_b), 32'd1);
            chk($sformatf("%s c%0d idx_b", tag, c), 32'(pidx_b), 32'(idx));
            chk($sformatf("%s c%0d attr_b", tag, c), 32'(pattr_b), 32'(attr & mask_of(1)));
         end
         ack         = (c == k);
         to          = (c == Tmo) && !ack;
         pad_ack     = ack;
         pad_attr_in = ret;
         err_clr     = (c == clr_cycle);
         @(posedge clk);
         if (ack) begin
            sh_a[idx] = ret & mask_of(0);
            if (!bad_b) sh_b[idx] = ret & mask_of(1);
         end
         exp_err_a = to ? 1'b1 : (err_clr ? 1'b0 : exp_err_a);
         exp_err_b = (to && !bad_b) ? 1'b1 : (err_clr ? 1'b0 : exp_err_b);
         if (ack || to) break;
      end
      @(negedge clk);
      pad_ack = 1'b0;
      err_clr = 1'b0;
      rd_idx  = idx;
      #1;
      chk({tag, " end req_a"}, 32'(req_a), 32'd0);
      chk({tag, " end req_b"}, 32'(req_b), 32'd0);
      chk({tag, " end busy_a"}, 32'(busy_a), 32'd0);
      chk({tag, " end ready_a"}, 32'(ready_a), 32'd1);
      chk({tag, " end ready_b"}, 32'(ready_b), 32'd1);
      chk({tag, " end done_a"}, 32'(done_a), 32'(k <= Tmo));
      chk({tag, " end done_b"}, 32'(done_b), 32'(!bad_b && k <= Tmo));
      chk({tag, " end err_a"}, 32'(err_a), 32'(exp_err_a));
      chk({tag, " end err_b"}, 32'(err_b), 32'(exp_err_b));
      chk({tag, " end rd_a"}, 32'(rd_a), 32'(sh_a[idx]));
      chk({tag, " end rd_b"}, 32'(rd_b), bad_b ? 32'd0 : 32'(sh_b[idx]));
   endtask

   initial begin
      rst         = 1'b1;
      wr_req      = 1'b0;
      wr_idx      = '0;
      wr_attr     = '0;
      pad_ack     = 1'b0;
      pad_attr_in = '0;
      rd_idx      = '0;
      err_clr     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sh_a[i] = '0;
         sh_b[i] = '0;
      end
      exp_err_a = 1'b0;
      exp_err_b = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst ready_a", 32'(ready_a), 32'd1);
      chk("rst req_a", 32'(req_a), 32'd0);
      chk("rst busy_a", 32'(busy_a), 32'd0);
      chk("rst done_a", 32'(done_a), 32'd0);
      chk("rst err_a", 32'(err_a), 32'd0);
      chk("rst attr_a", 32'(pattr_a), 32'd0);
      chk("rst ready_b", 32'(ready_b), 32'd1);
      sweep_shadows("rst");

      // T1: ack at cycle 3
      do_write("T1", 2'd1, 13'h1ABC, 3, 13'h1ABC, 0);
      // T2: PadType=1 masking on u_b, pad returns all ones
      do_write("T2", 2'd2, 13'h1FFF, 1, 13'h1FFF, 0);
      // T3: no ack -> 15 REQ cycles then timeout, shadow unchanged
      do_write("T3", 2'd0, 13'h0F0F, 99, 13'h1111, 0);
      sweep_shadows("T3");
      clear_err();
      // T4: ack on the 15th REQ cycle wins
      do_write("T4a", 2'd0, 13'h0AAA, Tmo, 13'h0AA5, 0);
      // T4: err_clr in the timeout cycle, set wins
      do_write("T4b", 2'd1, 13'h0123, 99, 13'h0000, Tmo);
      clear_err();
      // T5: index 3 is out of range for u_b only
      do_write("T5", 2'd3, 13'h1234, 2, 13'h1FFE, 0);
      sweep_shadows("T5");
      clear_err();

      // Randomised updates
      for (int n = 0; n < 24; n++) begin
         logic [1:0]  idx;
         logic [12:0] attr, ret;
         int          k, clr_cycle;
         idx       = 2'($urandom_range(0, 3));
         attr      = 13'($urandom);
         ret       = ($urandom_range(0, 1) == 1) ? attr : 13'($urandom);
         k         = $urandom_range(1, 18);
         clr_cycle = ($urandom_range(0, 3) == 0) ? $urandom_range(1, Tmo) : 0;
         do_write($sformatf("R%0d", n), idx, attr, k, ret, clr_cycle);
      end
      sweep_shadows("rand");

      // T6: reset in the middle of REQ, stray ack afterwards
      do_write("T6pre", 2'd3, 13'h1FFF, 99, 13'h0000, 0);
      @(negedge clk);
      wr_req  = 1'b1;
      wr_idx  = 2'd2;
      wr_attr = 13'h0555;
      @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
      chk("T6 req_a before rst", 32'(req_a), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("T6 rst req_a", 32'(req_a), 32'd0);
      chk("T6 rst req_b", 32'(req_b), 32'd0);
      chk("T6 rst idx_a", 32'(pidx_a), 32'd0);
      chk("T6 rst attr_a", 32'(pattr_a), 32'd0);
      chk("T6 rst done_a", 32'(done_a), 32'd0);
      chk("T6 rst err_a", 32'(err_a), 32'd0);
      chk("T6 rst err_b", 32'(err_b), 32'd0);
      chk("T6 rst busy_a", 32'(busy_a), 32'd0);
      for (int i = 0; i < 4; i++) begin
         sh_a[i] = '0;
         sh_b[i] = '0;
      end
      exp_err_a = 1'b0;
      exp_err_b = 1'b0;
      @(negedge clk);
      rst         = 1'b0;
      pad_ack     = 1'b1;
      pad_attr_in = 13'h1FFF;
      repeat (2) @(negedge clk);
      chk("T6 stray req_a", 32'(req_a), 32'd0);
      chk("T6 stray done_a", 32'(done_a), 32'd0);
      chk("T6 stray done_b", 32'(done_b), 32'd0);
      chk("T6 stray ready_a", 32'(ready_a), 32'd1);
      pad_ack = 1'b0;
      sweep_shadows("T6");
      do_write("T6post", 2'd2, 13'h0C3C, 4, 13'h0C3D, 0);
      sweep_shadows("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
